stopwatch_ctrl: RTL and testbench

- Run controller for the stopwatch datapath: owns the millisecond time base and the binary elapsed-time counter.
- Sequences start/stop/lap/clear from two button pulses.
- Drives the binary count consumed by count2watch, and from there bin2bcd and the display.
- Sits between the debounced button front end and the count2watch → bin2bcd chain.

---
 rtl/stopwatch_ctrl.sv | 124 ++++++++++++
 tb/tb_stopwatch_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run controller: millisecond prescaler, elapsed-ms counter, lap snapshot
// and start/stop/lap/clear sequencing. Define SW_SATURATE_EN to saturate-and-stop at MAX_COUNT.
module stopwatch_ctrl #(
  parameter int BITS      = 26,
  parameter int CLK_DIV   = 50000,
  parameter int MAX_COUNT = 35999999
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_stop,
  input  logic            lap_reset,
  output logic [BITS-1:0] count,
  output logic            running,
  output logic            lap_active,
  output logic            tick_ms,
  output logic            wrapped,
  output logic [1:0]      dbg_state
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_LAP  = 2'd2;
  localparam logic [1:0] ST_STOP = 2'd3;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BITS-1:0]  LIVE_MAX = BITS'(MAX_COUNT);

  logic [1:0]       r_state;
  logic [BITS-1:0]  r_live;
  logic [BITS-1:0]  r_lap;
  logic [DIV_W-1:0] r_div;

  logic [1:0]       w_state_nxt;
  logic             w_active;
  logic             w_tick;
  logic             w_at_max;
  logic             w_roll;
  logic             w_ss;
  logic             w_capture;
  logic             w_clear;

  assign w_active = (r_state == ST_RUN) || (r_state == ST_LAP);
  assign w_tick   = w_active && (r_div == DIV_LAST);
  assign w_at_max = (r_live == LIVE_MAX);
  assign w_roll   = w_tick && w_at_max;

`ifdef SW_SATURATE_EN
  // A saturated stop can only be left through clear or reset.
  assign w_ss = start_stop && !((r_state == ST_STOP) && w_at_max);
`else
  assign w_ss = start_stop;
`endif

  // start_stop has priority over lap_reset in every state.
  assign w_capture = (r_state == ST_RUN)  && !w_ss && lap_reset;
  assign w_clear   = (r_state == ST_STOP) && !w_ss && lap_reset;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_ss) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (w_ss)           w_state_nxt = ST_STOP;
        else if (lap_reset) w_state_nxt = ST_LAP;
      end
      ST_LAP: begin
        if (w_ss)           w_state_nxt = ST_STOP;
        else if (lap_reset) w_state_nxt = ST_RUN;
      end
      default: begin
        if (w_ss)           w_state_nxt = ST_RUN;
        else if (lap_reset) w_state_nxt = ST_IDLE;
      end
    endcase
`ifdef SW_SATURATE_EN
    if (w_roll) w_state_nxt = ST_STOP;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_live  <= '0;
      r_lap   <= '0;
      r_div   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clear) begin
        r_live <= '0;
        r_div  <= '0;
        r_lap  <= '0;
      end else begin
        // Prescaler holds in STOP so the sub-ms phase survives a pause.
        if (r_state == ST_IDLE)  r_div <= '0;
        else if (w_tick)         r_div <= '0;
        else if (w_active)       r_div <= r_div + DIV_W'(1);

        if (w_tick) begin
          if (w_at_max) begin
`ifdef SW_SATURATE_EN
            r_live <= LIVE_MAX;
`else
            r_live <= '0;
`endif
          end else begin
            r_live <= r_live + BITS'(1);
          end
        end

        if (w_capture) r_lap <= r_live;
      end
    end
  end

  assign count      = (r_state == ST_LAP) ? r_lap : r_live;
  assign running    = w_active;
  assign lap_active = (r_state == ST_LAP);
  assign tick_ms    = w_tick;
  assign wrapped    = w_roll;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios followed by random button/reset traffic,
// checked every cycle against an elapsed-run-cycles model of the stopwatch.
module tb_stopwatch_ctrl;

  localparam int BITS      = 26;
  localparam int CLK_DIV   = 4;
  localparam int MAX_COUNT = 20;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start_stop = 1'b0;
  logic            lap_reset = 1'b0;
  logic [BITS-1:0] count;
  logic            running;
  logic            lap_active;
  logic            tick_ms;
  logic            wrapped;
  logic [1:0]      dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: the stopwatch is described by how many clock edges it has spent running.
  bit m_idle;
  bit m_running;
  bit m_lap;
  int m_cycles;
  int m_lap_val;

  stopwatch_ctrl #(.BITS(BITS), .CLK_DIV(CLK_DIV), .MAX_COUNT(MAX_COUNT)) dut (
    .clk(clk), .reset(reset), .start_stop(start_stop), .lap_reset(lap_reset),
    .count(count), .running(running), .lap_active(lap_active),
    .tick_ms(tick_ms), .wrapped(wrapped), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  function automatic int model_live();
    int ms;
    ms = m_cycles / CLK_DIV;
`ifdef SW_SATURATE_EN
    return (ms > MAX_COUNT) ? MAX_COUNT : ms;
`else
    return ms % (MAX_COUNT + 1);
`endif
  endfunction

  function automatic bit model_tick();
    return m_running && ((m_cycles % CLK_DIV) == CLK_DIV - 1);
  endfunction

  task automatic model_edge(input bit ss, input bit lr, input bit rst);
    bit tick;
    int old_live;
    bit ss_eff;
    if (rst) begin
      m_idle = 1; m_running = 0; m_lap = 0; m_cycles = 0; m_lap_val = 0;
      return;
    end
    tick     = model_tick();
    old_live = model_live();
    ss_eff   = ss;
`ifdef SW_SATURATE_EN
    if (!m_idle && !m_running && old_live == MAX_COUNT) ss_eff = 0;
`endif
    if (m_running) m_cycles++;
    if (m_idle) begin
      if (ss_eff) begin m_idle = 0; m_running = 1; end
    end else if (m_running && !m_lap) begin
      if (ss_eff) m_running = 0;
      else if (lr) begin m_lap = 1; m_lap_val = old_live; end
    end else if (m_lap) begin
      if (ss_eff) begin m_running = 0; m_lap = 0; end
      else if (lr) m_lap = 0;
    end else begin
      if (ss_eff) m_running = 1;
      else if (lr) begin m_idle = 1; m_cycles = 0; m_lap_val = 0; end
    end
`ifdef SW_SATURATE_EN
    if (tick && old_live == MAX_COUNT) begin m_running = 0; m_lap = 0; end
`endif
  endtask

  task automatic check_outputs();
    bit tick;
    tick = model_tick();
    check("count",      32'(count),      32'(m_lap ? m_lap_val : model_live()));
    check("running",    32'(running),    32'(m_running));
    check("lap_active", 32'(lap_active), 32'(m_lap));
    check("tick_ms",    32'(tick_ms),    32'(tick));
    check("wrapped",    32'(wrapped),    32'(tick && model_live() == MAX_COUNT));
  endtask

  task automatic step(input bit ss, input bit lr, input bit rst);
    start_stop = ss;
    lap_reset  = lr;
    reset      = rst;
    @(posedge clk);
    model_edge(ss, lr, rst);
    @(negedge clk);
    check_outputs();
    start_stop = 0;
    lap_reset  = 0;
    reset      = 0;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  initial begin
    m_idle = 1; m_running = 0; m_lap = 0; m_cycles = 0; m_lap_val = 0;
    @(negedge clk);

    // Reset and idle behaviour
    step(0, 0, 1);
    step(0, 0, 1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    step(0, 1, 0);
    idle_steps(3);

    // Free run: 40 cycles gives 10 ms
    step(1, 0, 0);
    check("run_entry", 32'(running), 32'd1);
    idle_steps(40);
    check("cnt_after40", 32'(count), 32'd10);

    // Stop, clear, then lap at 5 and release at 8
    step(1, 0, 0);
    step(0, 1, 0);
    check("clr_count", 32'(count), 32'd0);
    step(1, 0, 0);
    idle_steps(20);
    step(0, 1, 0);
    idle_steps(12);
    check("lap_hold", 32'(count), 32'd5);
    check("lap_flag", 32'(lap_active), 32'd1);
    step(0, 1, 0);
    check("lap_release", 32'(count), 32'd8);

    // Pause keeps count and sub-ms phase, then resume
    step(1, 0, 0);
    idle_steps(20);
    check("pause_hold", 32'(count), 32'd8);
    step(1, 0, 0);
    idle_steps(6);
    step(1, 0, 0);
    step(0, 1, 0);
    check("idle_clear", 32'(count), 32'd0);

    // Run past MAX_COUNT
    step(1, 0, 0);
    idle_steps((MAX_COUNT + 1) * CLK_DIV + 10);
    step(1, 0, 0);
    step(1, 0, 0);
    idle_steps(5);

    // Simultaneous buttons from RUN, then mid-run reset
    step(0, 1, 0);
    step(0, 1, 0);
    step(1, 0, 0);
    idle_steps(9);
    step(1, 1, 0);
    idle_steps(3);
    step(1, 0, 0);
    idle_steps(10);
    step(0, 0, 1);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_running", 32'(running), 32'd0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 299) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
